// File: rtl/lerp_seg_find_if.sv
// Request/config/result bundle between the activation-path feeder and its
// segment finder.
interface lerp_seg_find_if #(
  parameter int unsigned S  = 32,
  parameter int unsigned AW = 3
) ();
  logic          start;
  logic [S-1:0]  x;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [S-1:0]  cfg_x;
  logic [S-1:0]  cfg_y;
  logic [S-1:0]  x_out;
  logic [S-1:0]  x1;
  logic [S-1:0]  x2;
  logic [S-1:0]  y1;
  logic [S-1:0]  y2;
  logic          sat;
  logic [S-1:0]  y_sat;
  logic          busy;
  logic          done;

  modport master (
    output start, x, cfg_we, cfg_addr, cfg_x, cfg_y,
    input  x_out, x1, x2, y1, y2, sat, y_sat, busy, done
  );

  modport slave (
    input  start, x, cfg_we, cfg_addr, cfg_x, cfg_y,
    output x_out, x1, x2, y1, y2, sat, y_sat, busy, done
  );
endinterface

// File: rtl/lerp_seg_find.sv
// Breakpoint-table segment finder feeding the float linear interpolator:
// scans for X[k-1] <= x < X[k], or saturates for out-of-range / NaN inputs.
module lerp_seg_find #(
  parameter int unsigned S  = 32,
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  lerp_seg_find_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [S-1:0]  x_q;
  logic [S-1:0]  tab_x [N];
  logic [S-1:0]  tab_y [N];

  logic          load_c;
  logic          sat_c;
  logic [S-1:0]  ysat_c;
  logic          nan_c;

  // Sign-magnitude a < b with -0 == +0; denormals ordered by raw magnitude.
  function automatic logic f_lt(input logic [S-1:0] a, input logic [S-1:0] b);
    logic [S-2:0] am;
    logic [S-2:0] bm;
    am = a[S-2:0];
    bm = b[S-2:0];
    if (am == '0 && bm == '0) return 1'b0;
    if (a[S-1] != b[S-1])     return a[S-1];
    if (a[S-1])               return am > bm;
    return am < bm;
  endfunction

  assign nan_c = (&x_q[30:23]) && (|x_q[22:0]);

  // Next-state and segment decision.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_c  = 1'b0;
    sat_c   = 1'b0;
    ysat_c  = x_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          idx_d   = AW'(1);
        end
      end
      SCAN: begin
        if (nan_c) begin
          load_c = 1'b1;
          sat_c  = 1'b1;
          ysat_c = x_q;
        end else if (f_lt(x_q, tab_x[0])) begin
          load_c = 1'b1;
          sat_c  = 1'b1;
          ysat_c = tab_y[0];
        end else if (!f_lt(x_q, tab_x[N-1])) begin
          load_c = 1'b1;
          sat_c  = 1'b1;
          ysat_c = tab_y[N-1];
        end else if (f_lt(x_q, tab_x[idx_q])) begin
          load_c = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
        if (load_c) state_d = EMIT;
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == IDLE && bus.start) x_q <= bus.x;
    end
  end

  // Table writes only while idle, so a same-cycle start scans the new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        tab_x[i] <= '0;
        tab_y[i] <= '0;
      end
    end else if (state_q == IDLE && bus.cfg_we && 32'(bus.cfg_addr) < N) begin
      tab_x[bus.cfg_addr] <= bus.cfg_x;
      tab_y[bus.cfg_addr] <= bus.cfg_y;
    end
  end

  // Result registers hold until the next decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.x_out <= '0;
      bus.x1    <= '0;
      bus.x2    <= '0;
      bus.y1    <= '0;
      bus.y2    <= '0;
      bus.sat   <= 1'b0;
      bus.y_sat <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.busy <= (state_d != IDLE);
      bus.done <= load_c;
      if (load_c) begin
        bus.x_out <= x_q;
        bus.sat   <= sat_c;
        if (sat_c) begin
          bus.y_sat <= ysat_c;
        end else begin
          bus.x1 <= tab_x[idx_q - AW'(1)];
          bus.x2 <= tab_x[idx_q];
          bus.y1 <= tab_y[idx_q - AW'(1)];
          bus.y2 <= tab_y[idx_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_lerp_seg_find.sv
// Scoreboard bench for lerp_seg_find with a 5-entry breakpoint table.
module tb_lerp_seg_find;

  localparam int unsigned S  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned AW = 3;

  typedef struct {
    logic        sat;
    logic [31:0] y_sat;
    logic [31:0] x_out;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y1;
    logic [31:0] y2;
    int          lat;
    int          issue;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   done_cnt;
  exp_t sb[$];

  lerp_seg_find_if #(.S(S), .AW(AW)) bus ();

  lerp_seg_find #(.S(S), .N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_seg(input logic [31:0] xo, input logic [31:0] a1,
                                  input logic [31:0] a2, input logic [31:0] b1,
                                  input logic [31:0] b2, input int lat);
    exp_t e;
    e.sat = 1'b0; e.y_sat = '0; e.x_out = xo;
    e.x1 = a1; e.x2 = a2; e.y1 = b1; e.y2 = b2;
    e.lat = lat; e.issue = 0;
    return e;
  endfunction

  function automatic exp_t mk_sat(input logic [31:0] xo, input logic [31:0] ys, input int lat);
    exp_t e;
    e.sat = 1'b1; e.y_sat = ys; e.x_out = xo;
    e.x1 = '0; e.x2 = '0; e.y1 = '0; e.y2 = '0;
    e.lat = lat; e.issue = 0;
    return e;
  endfunction

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got done with x_out=%h, expected no done (cycle %0d)", bus.x_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
        chk("sat", 32'(bus.sat), 32'(e.sat));
        chk("x_out", bus.x_out, e.x_out);
        if (e.sat) begin
          chk("y_sat", bus.y_sat, e.y_sat);
        end else begin
          chk("x1", bus.x1, e.x1);
          chk("x2", bus.x2, e.x2);
          chk("y1", bus.y1, e.y1);
          chk("y2", bus.y2, e.y2);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] xv, input bit push, input exp_t e);
    exp_t q;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    if (push) begin
      q = e;
      q.issue = cyc;
      sb.push_back(q);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int  base;
    bit  got;
    base = done_cnt;
    got  = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: got no done, expected done within 30 cycles", nm);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_sat"},   32'(bus.sat),  32'd0);
    chk({tag, "_y_sat"}, bus.y_sat, 32'd0);
    chk({tag, "_x_out"}, bus.x_out, 32'd0);
    chk({tag, "_x1"},    bus.x1, 32'd0);
    chk({tag, "_x2"},    bus.x2, 32'd0);
    chk({tag, "_y1"},    bus.y1, 32'd0);
    chk({tag, "_y2"},    bus.y2, 32'd0);
  endtask

  logic [31:0] tx [5];
  logic [31:0] ty [5];
  logic [31:0] vx [7];
  exp_t        ve [7];

  initial begin
    int base;
    n_cmp = 0; n_err = 0; done_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.x = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_x = '0; bus.cfg_y = '0;

    tx = '{32'hC0800000, 32'hC0000000, 32'h00000000, 32'h40000000, 32'h40800000};
    ty = '{32'h00000000, 32'h3E800000, 32'h3F000000, 32'h3F400000, 32'h3F800000};

    vx[0] = 32'h3F800000; ve[0] = mk_seg(32'h3F800000, 32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F400000, 4);
    vx[1] = 32'hC0A00000; ve[1] = mk_sat(32'hC0A00000, 32'h00000000, 2);
    vx[2] = 32'h40800000; ve[2] = mk_sat(32'h40800000, 32'h3F800000, 2);
    vx[3] = 32'hC0800000; ve[3] = mk_seg(32'hC0800000, 32'hC0800000, 32'hC0000000, 32'h00000000, 32'h3E800000, 2);
    vx[4] = 32'h80000000; ve[4] = mk_seg(32'h80000000, 32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F400000, 4);
    vx[5] = 32'h7FC00000; ve[5] = mk_sat(32'h7FC00000, 32'h7FC00000, 2);
    vx[6] = 32'h40400000; ve[6] = mk_seg(32'h40400000, 32'h40000000, 32'h40800000, 32'h3F400000, 32'h3F800000, 5);

    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(N); i++) begin
      @(negedge clk);
      bus.cfg_we = 1'b1; bus.cfg_addr = AW'(i); bus.cfg_x = tx[i]; bus.cfg_y = ty[i];
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;

    // Directed vectors, each start issued in the cycle right after the previous done.
    for (int i = 0; i < 7; i++) begin
      issue(vx[i], 1'b1, ve[i]);
      wait_done($sformatf("vec%0d", i));
    end

    // Start and cfg writes during a scan must be ignored.
    base = done_cnt;
    issue(32'h3F800000, 1'b1, ve[0]);
    bus.start = 1'b1; bus.x = 32'hC0A00000;
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd3; bus.cfg_x = 32'h0; bus.cfg_y = 32'h0;
    repeat (4) @(negedge clk);
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_one_done", 32'(done_cnt - base), 32'd1);
    issue(32'h3F800000, 1'b1, ve[0]);
    wait_done("readback");

    // Write and start in the same idle cycle: scan sees the new X[3]/Y[3].
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd3; bus.cfg_x = 32'h3F000000; bus.cfg_y = 32'h3F400000;
    bus.start = 1'b1; bus.x = 32'h3F800000;
    begin
      exp_t e;
      e = mk_seg(32'h3F800000, 32'h3F000000, 32'h40800000, 32'h3F400000, 32'h3F800000, 5);
      e.issue = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    wait_done("wr_start");

    // Reset in cycle 2 of a scan aborts it and clears the table.
    base = done_cnt;
    issue(32'h3F800000, 1'b0, ve[0]);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midscan_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - base), 32'd0);
    issue(32'h3F800000, 1'b1, mk_sat(32'h3F800000, 32'h00000000, 2));
    wait_done("post_rst");

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
